// File: rtl/rx_ingest_pkg.sv
// Shared definitions for the RX I/Q ingest front-end: control bit map,
// sign-extension helper and FIFO entry layout {last, q, i}.
package rx_ingest_pkg;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_CLR  = 1;
    localparam int CTRL_TPAT = 2;

    localparam int ADC_PORT_W = 16;
    localparam int SEXT_MAX_W = 32;

    // Shift the sign bit up to the MSB, then arithmetic-shift back down.
    function automatic logic [SEXT_MAX_W-1:0] sign_extend(
        input logic [SEXT_MAX_W-1:0] x,
        input int                    adc_w
    );
        logic signed [SEXT_MAX_W-1:0] t;
        t = x << (SEXT_MAX_W - adc_w);
        return t >>> (SEXT_MAX_W - adc_w);
    endfunction

    function automatic int entry_width(input int out_w);
        return 2 * out_w + 1;
    endfunction

    function automatic int entry_q_lsb(input int out_w);
        return out_w;
    endfunction

    function automatic int entry_last_bit(input int out_w);
        return 2 * out_w;
    endfunction

endpackage

// File: rtl/rx_ingest_fifo.sv
// Generic show-ahead synchronous FIFO with occupancy output; when empty the
// read port keeps presenting the most recently popped word.
module rx_ingest_fifo
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    rd_en,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    rd_vld,
    output logic [$clog2(DEPTH):0]  fill,
    output logic                    wr_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = DEPTH[CW-1:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] last_rd;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign pop     = rd_en && !empty;
    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign push    = wr_en && (!full || pop);
    assign wr_drop = wr_en && full && !pop;

    assign rd_vld  = !empty;
    assign fill    = count;
    assign rd_data = empty ? last_rd : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            last_rd <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + AW'(1);
                last_rd <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rx_iq_ingest.sv
// RX I/Q ingest: strobed ADC capture, sign extension, idle-gap burst framing, FIFO hand-off.
// Defining RX_IQ_INGEST_TESTPAT_EN adds a ramp test pattern selected by i_ctrl[2].
module rx_iq_ingest
    import rx_ingest_pkg::*;
#(
    parameter int ADC_W   = 12,
    parameter int OUT_W   = 16,
    parameter int DEPTH   = 64,
    parameter int GAP_CYC = 64,
    parameter int CNT_W   = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [31:0]            i_ctrl,
    input  logic [ADC_PORT_W-1:0]  i_fromADC_i,
    input  logic [ADC_PORT_W-1:0]  i_fromADC_q,
    input  logic                   i_fromADC_vld,
    output logic [OUT_W-1:0]       o_datarx_i,
    output logic [OUT_W-1:0]       o_datarx_q,
    output logic                   o_datarx_vld,
    output logic                   o_datarx_last,
    input  logic                   i_datarx_rdy,
    output logic [$clog2(DEPTH):0] o_fill,
    output logic                   o_overflow,
    output logic [CNT_W-1:0]       o_sample_cnt,
    output logic [CNT_W-1:0]       o_burst_cnt
);

    localparam int ENTRY_W    = entry_width(OUT_W);
    localparam int Q_LSB      = entry_q_lsb(OUT_W);
    localparam int LAST_BIT   = entry_last_bit(OUT_W);
    localparam int GAP_W      = $clog2(GAP_CYC);
    localparam int GAP_LAST_I = GAP_CYC - 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_LAST_I[GAP_W-1:0];

    logic                  en;
    logic                  clr;
    logic                  accept;
    logic                  expire;
    logic [ADC_PORT_W-1:0] raw_i;
    logic [ADC_PORT_W-1:0] raw_q;
    logic [SEXT_MAX_W-1:0] ext_i_full;
    logic [SEXT_MAX_W-1:0] ext_q_full;
    logic [OUT_W-1:0]      ext_i;
    logic [OUT_W-1:0]      ext_q;
    logic                  hold_full;
    logic [OUT_W-1:0]      hold_i;
    logic [OUT_W-1:0]      hold_q;
    logic [GAP_W-1:0]      gap_cnt;
    logic                  fifo_wr;
    logic [ENTRY_W-1:0]    fifo_wdata;
    logic [ENTRY_W-1:0]    fifo_rdata;
    logic                  fifo_drop;
    logic                  unused_bits;

    assign en     = i_ctrl[CTRL_EN];
    assign clr    = i_ctrl[CTRL_CLR];
    assign accept = en && i_fromADC_vld;
    // A strobe on the expiry cycle wins: the held sample goes out as a mid-burst write.
    assign expire = en && hold_full && !accept && (gap_cnt == GAP_LAST);

`ifdef RX_IQ_INGEST_TESTPAT_EN
    logic             tpat_sel;
    logic [ADC_W-1:0] ramp;
    logic [ADC_W-1:0] ramp_n;

    assign tpat_sel = i_ctrl[CTRL_TPAT];
    assign ramp_n   = ~ramp;

    always_comb begin
        raw_i = i_fromADC_i;
        raw_q = i_fromADC_q;
        if (tpat_sel) begin
            raw_i = ADC_PORT_W'(ramp);
            raw_q = ADC_PORT_W'(ramp_n);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ramp <= '0;
        end else if (accept && tpat_sel) begin
            ramp <= ramp + ADC_W'(1);
        end
    end

    assign unused_bits = ^{i_ctrl[31:3], ext_i_full[SEXT_MAX_W-1:OUT_W],
                           ext_q_full[SEXT_MAX_W-1:OUT_W]};
`else
    assign raw_i = i_fromADC_i;
    assign raw_q = i_fromADC_q;

    assign unused_bits = ^{i_ctrl[31:3], i_ctrl[CTRL_TPAT],
                           ext_i_full[SEXT_MAX_W-1:OUT_W],
                           ext_q_full[SEXT_MAX_W-1:OUT_W]};
`endif

    assign ext_i_full = sign_extend(SEXT_MAX_W'(raw_i), ADC_W);
    assign ext_q_full = sign_extend(SEXT_MAX_W'(raw_q), ADC_W);
    assign ext_i      = ext_i_full[OUT_W-1:0];
    assign ext_q      = ext_q_full[OUT_W-1:0];

    assign fifo_wr    = (accept && hold_full) || expire;
    assign fifo_wdata = {expire, hold_q, hold_i};

    // One-entry hold stage: the newest sample waits here until the next
    // strobe or the idle gap decides whether it ends the burst.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hold_full <= 1'b0;
            hold_i    <= '0;
            hold_q    <= '0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_i    <= ext_i;
            hold_q    <= ext_q;
        end else if (expire) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            gap_cnt <= '0;
        end else if (accept || expire) begin
            gap_cnt <= '0;
        end else if (en && hold_full) begin
            gap_cnt <= gap_cnt + GAP_W'(1);
        end
    end

    // Status registers; a clear pulse overrides any simultaneous update.
    always_ff @(posedge i_clk) begin
        if (i_rst || clr) begin
            o_overflow   <= 1'b0;
            o_sample_cnt <= '0;
            o_burst_cnt  <= '0;
        end else begin
            if (fifo_drop) begin
                o_overflow <= 1'b1;
            end
            if (accept) begin
                o_sample_cnt <= o_sample_cnt + CNT_W'(1);
            end
            if (expire) begin
                o_burst_cnt <= o_burst_cnt + CNT_W'(1);
            end
        end
    end

    rx_ingest_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .rst     (i_rst),
        .wr_en   (fifo_wr),
        .wr_data (fifo_wdata),
        .rd_en   (i_datarx_rdy),
        .rd_data (fifo_rdata),
        .rd_vld  (o_datarx_vld),
        .fill    (o_fill),
        .wr_drop (fifo_drop)
    );

    assign o_datarx_i    = fifo_rdata[OUT_W-1:0];
    assign o_datarx_q    = fifo_rdata[Q_LSB +: OUT_W];
    assign o_datarx_last = o_datarx_vld && fifo_rdata[LAST_BIT];

endmodule

// File: tb/tb_rx_iq_ingest.sv
// Self-checking bench for rx_iq_ingest: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_rx_iq_ingest;

    localparam int ADC_W   = 12;
    localparam int OUT_W   = 16;
    localparam int DEPTH   = 64;
    localparam int GAP_CYC = 64;
    localparam int CNT_W   = 32;
    localparam int FILL_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       ctrl;
    logic [15:0]       adc_i;
    logic [15:0]       adc_q;
    logic              adc_vld;
    logic              rdy;
    logic [OUT_W-1:0]  out_i;
    logic [OUT_W-1:0]  out_q;
    logic              out_vld;
    logic              out_last;
    logic [FILL_W-1:0] fill;
    logic              overflow;
    logic [CNT_W-1:0]  sample_cnt;
    logic [CNT_W-1:0]  burst_cnt;

    always #5 clk = ~clk;

    rx_iq_ingest #(
        .ADC_W   (ADC_W),
        .OUT_W   (OUT_W),
        .DEPTH   (DEPTH),
        .GAP_CYC (GAP_CYC),
        .CNT_W   (CNT_W)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_ctrl        (ctrl),
        .i_fromADC_i   (adc_i),
        .i_fromADC_q   (adc_q),
        .i_fromADC_vld (adc_vld),
        .o_datarx_i    (out_i),
        .o_datarx_q    (out_q),
        .o_datarx_vld  (out_vld),
        .o_datarx_last (out_last),
        .i_datarx_rdy  (rdy),
        .o_fill        (fill),
        .o_overflow    (overflow),
        .o_sample_cnt  (sample_cnt),
        .o_burst_cnt   (burst_cnt)
    );

    typedef struct {
        int i;
        int q;
        bit last;
    } entry_t;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit started     = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: plain arithmetic sign extension and a queue standing in for the FIFO.
    entry_t m_q[$];
    bit     m_hold;
    int     m_hold_i, m_hold_q, m_gap, m_last_i, m_last_q, m_ramp;
    longint m_scnt, m_bcnt;
    bit     m_ovf;

    function automatic int sextm(input int raw);
        int x;
        x = raw % (1 << ADC_W);
        if (x >= (1 << (ADC_W - 1))) return x - (1 << ADC_W) + (1 << OUT_W);
        return x;
    endfunction

    always @(posedge clk) begin : model
        bit en, clr, acc, expire, pop, wr, old_hold;
        int size0, si, sq;
        entry_t e;
        if (rst) begin
            m_q.delete();
            m_hold = 0; m_hold_i = 0; m_hold_q = 0; m_gap = 0;
            m_last_i = 0; m_last_q = 0; m_ramp = 0;
            m_scnt = 0; m_bcnt = 0; m_ovf = 0;
        end else begin
            en  = ctrl[0];
            clr = ctrl[1];
            si  = sextm(int'(adc_i));
            sq  = sextm(int'(adc_q));
            acc = en && adc_vld;
`ifdef RX_IQ_INGEST_TESTPAT_EN
            if (ctrl[2]) begin
                si = sextm(m_ramp);
                sq = sextm((1 << ADC_W) - 1 - m_ramp);
                if (acc) m_ramp = (m_ramp + 1) % (1 << ADC_W);
            end
`endif
            old_hold = m_hold;
            expire   = en && old_hold && !acc && (m_gap == GAP_CYC - 1);
            wr       = (acc && old_hold) || expire;
            size0    = m_q.size();
            pop      = rdy && (size0 > 0);
            if (pop) begin
                e = m_q.pop_front();
                m_last_i = e.i;
                m_last_q = e.q;
            end
            if (wr) begin
                if (size0 < DEPTH || pop) m_q.push_back('{i: m_hold_i, q: m_hold_q, last: expire});
                else m_ovf = 1;
            end
            if (acc) m_scnt = m_scnt + 1;
            if (expire) m_bcnt = m_bcnt + 1;
            if (clr) begin
                m_ovf = 0; m_scnt = 0; m_bcnt = 0;
            end
            if (acc) begin
                m_hold = 1; m_hold_i = si; m_hold_q = sq;
            end else if (expire) begin
                m_hold = 0;
            end
            if (acc || expire) m_gap = 0;
            else if (en && old_hold) m_gap = m_gap + 1;
        end
    end

    // Compare process plus capture of delivered beats for the directed checks.
    entry_t cap[$];
    bit     prev_vld = 1'b0;
    int     rise_cyc = -1;

    always @(negedge clk) begin
        if (started) begin
            checkOutput("vld", 64'(out_vld), 64'(m_q.size() > 0));
            checkOutput("fill", 64'(fill), 64'(m_q.size()));
            checkOutput("overflow", 64'(overflow), 64'(m_ovf));
            checkOutput("sample_cnt", 64'(sample_cnt), 64'(m_scnt));
            checkOutput("burst_cnt", 64'(burst_cnt), 64'(m_bcnt));
            if (m_q.size() > 0) begin
                checkOutput("data_i", 64'(out_i), 64'(m_q[0].i));
                checkOutput("data_q", 64'(out_q), 64'(m_q[0].q));
                checkOutput("last", 64'(out_last), 64'(m_q[0].last));
            end else begin
                checkOutput("held_i", 64'(out_i), 64'(m_last_i));
                checkOutput("held_q", 64'(out_q), 64'(m_last_q));
            end
            if (out_vld && rdy) cap.push_back('{i: int'(out_i), q: int'(out_q), last: out_last});
            if (out_vld && !prev_vld) rise_cyc = cyc;
            prev_vld = out_vld;
        end
    end

    function automatic int capI(input int k);
        return (k < cap.size()) ? cap[k].i : -1;
    endfunction

    function automatic int capQ(input int k);
        return (k < cap.size()) ? cap[k].q : -1;
    endfunction

    function automatic int capLast(input int k);
        return (k < cap.size()) ? int'(cap[k].last) : -1;
    endfunction

    task automatic applyStimulus(input logic v, input logic [15:0] i, input logic [15:0] q,
                                 input logic r);
        adc_vld = v;
        adc_i   = i;
        adc_q   = q;
        rdy     = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n, input logic r);
        repeat (n) applyStimulus(1'b0, 16'h0, 16'h0, r);
    endtask

    task automatic pulseClear();
        ctrl = ctrl | 32'h2;
        @(posedge clk);
        #1;
        ctrl = ctrl & ~32'h2;
    endtask

    task automatic applyReset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("[TB] FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int n, lasts, drive_cyc;
        rst = 1'b1; ctrl = 32'h1; adc_vld = 1'b0; adc_i = '0; adc_q = '0; rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        started = 1'b1;

        $display("[TB] reset state");
        checkOutput("rst_vld", 64'(out_vld), 64'd0);
        checkOutput("rst_fill", 64'(fill), 64'd0);
        checkOutput("rst_i", 64'(out_i), 64'd0);
        checkOutput("rst_cnt", 64'(sample_cnt), 64'd0);

        $display("[TB] burst of 8, strobe every 2nd cycle");
        cap.delete();
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 16'(16'h0123 + k), 16'h0FFF, 1'b1);
            applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
        end
        idleCycles(100, 1'b1);
        checkOutput("b8_count", 64'(cap.size()), 64'd8);
        for (int k = 0; k < 8; k++) begin
            checkOutput("b8_i", 64'(capI(k)), 64'(32'h0123 + k));
            checkOutput("b8_q", 64'(capQ(k)), 64'h0FFFF);
            checkOutput("b8_last", 64'(capLast(k)), 64'(k == 7));
        end
        checkOutput("b8_samples", 64'(sample_cnt), 64'd8);
        checkOutput("b8_bursts", 64'(burst_cnt), 64'd1);

        $display("[TB] single strobe gap timing");
        pulseClear();
        cap.delete();
        drive_cyc = cyc;
        applyStimulus(1'b1, 16'h0800, 16'h07FF, 1'b1);
        idleCycles(GAP_CYC + 5, 1'b1);
        checkOutput("single_count", 64'(cap.size()), 64'd1);
        checkOutput("single_i", 64'(capI(0)), 64'h0F800);
        checkOutput("single_q", 64'(capQ(0)), 64'h007FF);
        checkOutput("single_last", 64'(capLast(0)), 64'd1);
        checkOutput("single_latency", 64'(rise_cyc - drive_cyc), 64'(GAP_CYC + 1));

        cap.delete();
        applyStimulus(1'b1, 16'h0001, 16'h0, 1'b1);
        idleCycles(GAP_CYC - 1, 1'b1);
        applyStimulus(1'b1, 16'h0002, 16'h0, 1'b1);
        idleCycles(GAP_CYC + 5, 1'b1);
        checkOutput("expiry_count", 64'(cap.size()), 64'd2);
        checkOutput("expiry_first_last", 64'(capLast(0)), 64'd0);
        checkOutput("expiry_second_i", 64'(capI(1)), 64'd2);
        checkOutput("expiry_second_last", 64'(capLast(1)), 64'd1);
        checkOutput("expiry_bursts", 64'(burst_cnt), 64'd2);

        $display("[TB] overflow with rdy low");
        pulseClear();
        cap.delete();
        for (int k = 1; k <= 70; k++) applyStimulus(1'b1, 16'(k), 16'(16'h0100 + k), 1'b0);
        checkOutput("ovf_fill", 64'(fill), 64'(DEPTH));
        checkOutput("ovf_flag", 64'(overflow), 64'd1);
        checkOutput("ovf_samples", 64'(sample_cnt), 64'd70);
        idleCycles(100, 1'b1);
        checkOutput("ovf_count", 64'(cap.size()), 64'd65);
        for (int k = 0; k < 64; k++) checkOutput("ovf_order", 64'(capI(k)), 64'(k + 1));
        checkOutput("ovf_tail_i", 64'(capI(64)), 64'd70);
        checkOutput("ovf_tail_last", 64'(capLast(64)), 64'd1);
        pulseClear();
        checkOutput("clr_flag", 64'(overflow), 64'd0);
        checkOutput("clr_samples", 64'(sample_cnt), 64'd0);
        checkOutput("clr_bursts", 64'(burst_cnt), 64'd0);

        $display("[TB] rdy toggling, back-to-back strobes");
        cap.delete();
        for (int k = 0; k < 20; k++) applyStimulus(1'b1, 16'(16'h0200 + k), 16'(16'h0300 + k), 1'(k % 2 == 0));
        idleCycles(GAP_CYC + 10, 1'b1);
        checkOutput("tog_count", 64'(cap.size()), 64'd20);
        for (int k = 0; k < 20; k++) begin
            checkOutput("tog_i", 64'(capI(k)), 64'(32'h0200 + k));
            checkOutput("tog_last", 64'(capLast(k)), 64'(k == 19));
        end

        $display("[TB] enable low ignores strobes");
        ctrl = 32'h0;
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, 16'h0555, 16'h0555, 1'b1);
        ctrl = 32'h1;
        checkOutput("dis_samples", 64'(sample_cnt), 64'd20);
        checkOutput("dis_fill", 64'(fill), 64'd0);

        $display("[TB] reset mid-burst");
        pulseClear();
        cap.delete();
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 16'(16'h0010 + k), 16'h0, 1'b1);
        rst = 1'b1;
        applyStimulus(1'b1, 16'h0013, 16'h0, 1'b1);
        rst = 1'b0;
        checkOutput("mid_rst_vld", 64'(out_vld), 64'd0);
        checkOutput("mid_rst_last", 64'(out_last), 64'd0);
        checkOutput("mid_rst_i", 64'(out_i), 64'd0);
        checkOutput("mid_rst_fill", 64'(fill), 64'd0);
        checkOutput("mid_rst_samples", 64'(sample_cnt), 64'd0);
        idleCycles(GAP_CYC + 10, 1'b1);
        lasts = 0;
        foreach (cap[k]) lasts += int'(cap[k].last);
        checkOutput("mid_rst_no_last", 64'(lasts), 64'd0);
        cap.delete();
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, 16'(16'h0020 + k), 16'h0, 1'b1);
        idleCycles(GAP_CYC + 10, 1'b1);
        checkOutput("post_rst_count", 64'(cap.size()), 64'd4);
        checkOutput("post_rst_first", 64'(capI(0)), 64'h020);
        checkOutput("post_rst_last", 64'(capLast(3)), 64'd1);
        checkOutput("post_rst_samples", 64'(sample_cnt), 64'd4);
        checkOutput("post_rst_bursts", 64'(burst_cnt), 64'd1);

`ifdef RX_IQ_INGEST_TESTPAT_EN
        $display("[TB] test pattern ramp");
        applyReset();
        cap.delete();
        ctrl = 32'h5;
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, 16'h0ABC, 16'h0123, 1'b1);
        idleCycles(GAP_CYC + 10, 1'b1);
        ctrl = 32'h1;
        checkOutput("tpat_count", 64'(cap.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            checkOutput("tpat_i", 64'(capI(k)), 64'(k));
            checkOutput("tpat_q", 64'(capQ(k)), 64'(32'hFFFF - k));
        end
`endif

        n = miscompares;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, n);
        $finish;
    end

endmodule

// File: doc/rx_iq_ingest.md
Name: rx_iq_ingest

Overview:
- Parametrised front-end for the RX signal-processing chain. It accepts strobed ADC I/Q samples, sign-extends them from ADC_W to OUT_W, and marks end-of-burst after a configurable idle gap.
- Samples are buffered in a FIFO and delivered downstream on a valid/ready handshake with a last flag.
- Sits between the fmcomms ADC interface and the RX DSP (carrier correction / SRRC) in the i_clk domain.

Parameters:
- ADC_W, 12, ADC sample width; input LSBs [ADC_W-1:0] are used, upper bits are ignored. Range 2..OUT_W.
- OUT_W, 16, output sample width.
- DEPTH, 64, FIFO depth in entries; power of 2, minimum 4.
- GAP_CYC, 64, idle i_clk cycles without i_fromADC_vld that close a burst; minimum 2.
- CNT_W, 32, width of the sample and burst counters.

Ports:
- i_clk in 1: single clock for all logic.
- i_rst in 1: reset, synchronous, active-high.
- i_ctrl in 32: control. [0] enable; [1] clear overflow and counters (pulse); [2] test-pattern select (see Optional Feature); others reserved.
- i_fromADC_i in 16: ADC I sample; bits [ADC_W-1:0] are significant.
- i_fromADC_q in 16: ADC Q sample.
- i_fromADC_vld in 1: one-cycle strobe per sample. May be asserted on consecutive cycles.
- o_datarx_i out OUT_W: sign-extended I.
- o_datarx_q out OUT_W: sign-extended Q.
- o_datarx_vld out 1: output valid.
- o_datarx_last out 1: marks the final sample of a burst.
- i_datarx_rdy in 1: downstream ready.
- o_fill out log2(DEPTH)+1: FIFO occupancy.
- o_overflow out 1: sticky; set when a FIFO write is dropped.
- o_sample_cnt out CNT_W: accepted samples; wraps at 2^CNT_W.
- o_burst_cnt out CNT_W: closed bursts; wraps.

Behaviour:
- Reset: all outputs 0; FIFO empty; hold register empty; gap counter 0.
- Sign extension: out = {{(OUT_W-ADC_W){x[ADC_W-1]}}, x[ADC_W-1:0]}. Example with ADC_W=12: 0x0800 → 0xF800.
- Enable low (i_ctrl[0]=0):
  - Input strobes are ignored and the gap counter is frozen.
  - The FIFO still drains.
  - The hold register keeps its content.
- Hold stage: each accepted sample is loaded into a one-entry hold register, and o_sample_cnt increments.
  - If hold is full when a new sample is accepted, the held sample is written to the FIFO with last=0 in the same cycle.
- Gap counter:
  - Clears on each accepted sample; otherwise increments while hold is full.
  - When it reaches GAP_CYC-1 with no strobe, the held sample is written with last=1, hold empties, and o_burst_cnt increments.
  - A strobe in that same cycle takes priority: no last is produced and the gap restarts.
- FIFO: show-ahead. A write at cycle t into an empty FIFO gives o_datarx_vld=1 at t+1.
  - The entry is popped when o_datarx_vld && i_datarx_rdy.
  - Output data and last stay stable while vld=1 and rdy=0.
- Full:
  - A write in a cycle with no pop is dropped, o_overflow is set, and counters are unaffected.
  - A write and pop in the same cycle when full is accepted; fill is unchanged.
- Empty: vld=0; data outputs hold their last value.
- Clear pulse (i_ctrl[1]=1): clears o_overflow, o_sample_cnt and o_burst_cnt next cycle. FIFO and hold are unaffected. If clear coincides with an increment, clear wins.
- Reset mid-burst: the held sample and FIFO contents are discarded; no last is emitted.

Optional Feature:
- Macro: RX_IQ_INGEST_TESTPAT_EN.
- Defined: when i_ctrl[2]=1, accepted strobes take I = ADC_W-bit ramp counter and Q = bitwise NOT of the ramp.
  - The ramp increments per strobe and resets to 0.
  - The result is then sign-extended as normal.
- Undefined: i_ctrl[2] is ignored, and no ramp logic is synthesised.

Decomposition:
- Package rx_ingest_pkg:
  - Ctrl bit indices: CTRL_EN=0, CTRL_CLR=1, CTRL_TPAT=2.
  - Sign-extend function.
  - FIFO entry layout {last, q, i} of width 2*OUT_W+1.
- Sub-module rx_ingest_fifo: generic show-ahead synchronous FIFO, parametrised by width and depth, with fill output.

Test Plan:
- Strobe every 2nd cycle, 8 samples I=0x0123..0x012A, Q=0x0FFF, then 100 idle cycles, rdy=1. Expect 8 outputs; Q=0xFFFF; last only on the 8th; o_burst_cnt=1; o_sample_cnt=8.
- Single strobe I=0x0800, then idle GAP_CYC cycles. Expect output 0xF800 with last=1, exactly GAP_CYC+1 cycles after the strobe; a strobe arriving on expiry cycle GAP_CYC-1 instead gives no last.
- rdy=0 with 70 consecutive strobes, DEPTH=64. Expect fill=64, o_overflow=1, and the first 64 samples (hold-stage order) delivered intact when rdy=1. Then pulse clear → overflow=0, counters=0.
- rdy toggling 1/0 every cycle with back-to-back strobes. Output data stable while stalled; no loss or duplication; order preserved.
- Assert i_rst after sample 3 of a 10-sample burst. All outputs 0 next cycle; no last emitted; a new burst after reset starts clean.
- With RX_IQ_INGEST_TESTPAT_EN and i_ctrl=0x5, 4 strobes. Expect I=0,1,2,3 and Q=0xFFFF,0xFFFE,0xFFFD,0xFFFC (12→16 sign-extended).
